// File: rtl/byte_to_pixel_unpacker_if.sv
// ---------------------------------------------------------------------------
// byte_to_pixel_unpacker_if
//   Bundles the RX byte stream and the per-channel VRAM write bus of the
//   byte_to_pixel_unpacker.
//
//   Handshake: en qualifies data8b on every rising dclk edge. There is no
//   ready / back-pressure path, so the unpacker accepts every byte presented
//   with en=1. A cycle with en=0 ends the current frame.
//
//   master : RX frame parser side (drives data8b/en, observes the VRAM bus)
//   slave  : unpacker side (consumes data8b/en, drives the VRAM bus)
//
//   Signals: data8b, en, addr2vram, data_rgb, wea (one-hot per channel),
//            count, pix_done, err_short, frame_cnt, dbg_state (1 = STREAM).
//   Optional (UNPACK_CHKSUM_EN defined): chksum[15:0], chksum_vld.
// ---------------------------------------------------------------------------
interface byte_to_pixel_unpacker_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 17
);
    localparam int CNT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [DATA_W-1:0] data8b;
    logic              en;
    logic [ADDR_W-1:0] addr2vram;
    logic [DATA_W-1:0] data_rgb;
    logic [NUM_CH-1:0] wea;
    logic [CNT_W-1:0]  count;
    logic              pix_done;
    logic              err_short;
    logic [15:0]       frame_cnt;
    logic              dbg_state;
`ifdef UNPACK_CHKSUM_EN
    logic [15:0]       chksum;
    logic              chksum_vld;

    modport master (output data8b, en,
                    input  addr2vram, data_rgb, wea, count, pix_done,
                           err_short, frame_cnt, dbg_state, chksum, chksum_vld);
    modport slave  (input  data8b, en,
                    output addr2vram, data_rgb, wea, count, pix_done,
                           err_short, frame_cnt, dbg_state, chksum, chksum_vld);
`else
    modport master (output data8b, en,
                    input  addr2vram, data_rgb, wea, count, pix_done,
                           err_short, frame_cnt, dbg_state);
    modport slave  (input  data8b, en,
                    output addr2vram, data_rgb, wea, count, pix_done,
                           err_short, frame_cnt, dbg_state);
`endif
endinterface

// File: rtl/byte_to_pixel_unpacker.sv
// ---------------------------------------------------------------------------
// byte_to_pixel_unpacker
//   Hunts the RX payload byte stream for a {start_addr, MARKER} header, then
//   deals the following bytes round-robin onto NUM_CH colour-plane VRAM
//   write ports, advancing the VRAM address once per complete pixel and
//   wrapping to 0 after MAX_ADDR-1. All outputs are registered (1 clk
//   latency from an accepted byte to its write).
//
//   Ports:
//     dclk  - clock
//     rst   - synchronous, active-high reset
//     bus   - byte_to_pixel_unpacker_if.slave (stream in, VRAM bus out,
//             dbg_state exposes the HUNT/STREAM state)
//
//   Optional feature macro: UNPACK_CHKSUM_EN adds a 16-bit wrapping sum of
//   each frame's payload bytes (chksum) with a 1-clk chksum_vld pulse on the
//   edge that closes the frame.
// ---------------------------------------------------------------------------
module byte_to_pixel_unpacker #(
    parameter int          DATA_W     = 8,
    parameter int          NUM_CH     = 3,
    parameter int          ADDR_W     = 17,
    parameter int          HDR_ADDR_W = 24,
    parameter int          MARKER_W   = 32,
    parameter logic [MARKER_W-1:0] MARKER = MARKER_W'(32'h0440_0000),
    parameter int          MAX_ADDR   = 76800
) (
    input  logic                       dclk,
    input  logic                       rst,
    byte_to_pixel_unpacker_if.slave    bus
);
    localparam int CNT_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // Only the header address bits that survive truncation to ADDR_W can
    // influence behaviour, so the window keeps just those plus the marker.
    localparam int KEEP_W = (ADDR_W < HDR_ADDR_W) ? ADDR_W : HDR_ADDR_W;
    localparam int WIN_W  = MARKER_W + KEEP_W;
    localparam int HOLD_W = WIN_W - DATA_W;
    localparam logic [CNT_W-1:0]  LAST_CH   = CNT_W'(NUM_CH - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ADDR - 1);

    typedef enum logic {S_HUNT = 1'b0, S_STREAM = 1'b1} state_t;

    state_t              r_state, w_state_next;
    logic [HOLD_W-1:0]   r_shift, w_shift_next;
    logic [ADDR_W-1:0]   r_ptr, w_ptr_next;
    logic [CNT_W-1:0]    r_ch, w_ch_next;
    logic [ADDR_W-1:0]   r_addr, w_addr_next;
    logic [DATA_W-1:0]   r_data, w_data_next;
    logic [NUM_CH-1:0]   r_wea, w_wea_next;
    logic [CNT_W-1:0]    r_count, w_count_next;
    logic                r_pix_done, w_pix_done_next;
    logic                r_err_short, w_err_short_next;
    logic [15:0]         r_frame_cnt, w_frame_cnt_next;
`ifdef UNPACK_CHKSUM_EN
    logic [15:0]         r_sum, w_sum_next;
    logic                r_sum_vld, w_sum_vld_next;
`endif

    // Window = stored history with the incoming byte appended (newest at LSB).
    logic [WIN_W-1:0]    w_win;
    logic                w_marker_hit;
    logic [ADDR_W-1:0]   w_hdr_addr;
    logic [ADDR_W-1:0]   w_ptr_inc;

    assign w_win        = {r_shift, bus.data8b};
    assign w_marker_hit = (w_win[MARKER_W-1:0] == MARKER);
    assign w_hdr_addr   = ADDR_W'(w_win[MARKER_W +: KEEP_W]);
    assign w_ptr_inc    = (r_ptr == LAST_ADDR) ? '0 : r_ptr + ADDR_W'(1);

    always_ff @(posedge dclk) begin
        if (rst) begin
            r_state     <= S_HUNT;
            r_shift     <= '0;
            r_ptr       <= '0;
            r_ch        <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_wea       <= '0;
            r_count     <= '0;
            r_pix_done  <= 1'b0;
            r_err_short <= 1'b0;
            r_frame_cnt <= '0;
`ifdef UNPACK_CHKSUM_EN
            r_sum       <= '0;
            r_sum_vld   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_shift     <= w_shift_next;
            r_ptr       <= w_ptr_next;
            r_ch        <= w_ch_next;
            r_addr      <= w_addr_next;
            r_data      <= w_data_next;
            r_wea       <= w_wea_next;
            r_count     <= w_count_next;
            r_pix_done  <= w_pix_done_next;
            r_err_short <= w_err_short_next;
            r_frame_cnt <= w_frame_cnt_next;
`ifdef UNPACK_CHKSUM_EN
            r_sum       <= w_sum_next;
            r_sum_vld   <= w_sum_vld_next;
`endif
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_shift_next     = r_shift;
        w_ptr_next       = r_ptr;
        w_ch_next        = r_ch;
        w_addr_next      = r_addr;
        w_data_next      = r_data;
        w_wea_next       = '0;
        w_count_next     = r_count;
        w_pix_done_next  = 1'b0;
        w_err_short_next = 1'b0;
        w_frame_cnt_next = r_frame_cnt;
`ifdef UNPACK_CHKSUM_EN
        w_sum_next       = r_sum;
        w_sum_vld_next   = 1'b0;
`endif
        if (bus.en) begin
            w_shift_next = w_win[HOLD_W-1:0];
            if (r_state == S_HUNT) begin
                if (w_marker_hit) begin
                    w_state_next = S_STREAM;
                    w_ch_next    = '0;
                    w_ptr_next   = ({{(32-ADDR_W){1'b0}}, w_hdr_addr} >= 32'(MAX_ADDR))
                                   ? '0 : w_hdr_addr;
`ifdef UNPACK_CHKSUM_EN
                    w_sum_next   = '0;
`endif
                end
            end else begin
                // Every byte in STREAM is payload, including marker look-alikes.
                w_data_next  = bus.data8b;
                w_wea_next   = NUM_CH'(1) << r_ch;
                w_count_next = r_ch;
                w_addr_next  = r_ptr;
`ifdef UNPACK_CHKSUM_EN
                w_sum_next   = r_sum + 16'(bus.data8b);
`endif
                if (r_ch == LAST_CH) begin
                    w_pix_done_next = 1'b1;
                    w_ch_next       = '0;
                    w_ptr_next      = w_ptr_inc;
                end else begin
                    w_ch_next       = r_ch + CNT_W'(1);
                end
            end
        end else begin
            w_shift_next = '0;
            if (r_state == S_STREAM) begin
                // End of frame: a partial pixel stays written, pointer untouched.
                w_state_next     = S_HUNT;
                w_addr_next      = '0;
                w_count_next     = '0;
                w_ch_next        = '0;
                w_err_short_next = (r_ch != '0);
                w_frame_cnt_next = (r_frame_cnt != 16'hFFFF) ? r_frame_cnt + 16'd1
                                                             : r_frame_cnt;
`ifdef UNPACK_CHKSUM_EN
                w_sum_vld_next   = 1'b1;
`endif
            end
        end
    end

    assign bus.addr2vram = r_addr;
    assign bus.data_rgb  = r_data;
    assign bus.wea       = r_wea;
    assign bus.count     = r_count;
    assign bus.pix_done  = r_pix_done;
    assign bus.err_short = r_err_short;
    assign bus.frame_cnt = r_frame_cnt;
    assign bus.dbg_state = (r_state == S_STREAM);
`ifdef UNPACK_CHKSUM_EN
    assign bus.chksum     = r_sum;
    assign bus.chksum_vld = r_sum_vld;
`endif

endmodule

// File: tb/tb_byte_to_pixel_unpacker.sv
// ---------------------------------------------------------------------------
// tb_byte_to_pixel_unpacker
//   Directed and randomized frames for byte_to_pixel_unpacker with default
//   parameters. A frame-level reference model locates the header by searching
//   the byte list for the marker and computes each payload write with plain
//   arithmetic (channel = index mod NUM_CH, address = start + index div
//   NUM_CH wrapped at MAX_ADDR); expected writes sit in exp_q.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_byte_to_pixel_unpacker;
    localparam int DATA_W   = 8;
    localparam int NUM_CH   = 3;
    localparam int ADDR_W   = 17;
    localparam int MAX_ADDR = 76800;
    localparam int CNT_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int EXP_W    = ADDR_W + DATA_W + NUM_CH + CNT_W + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    byte_to_pixel_unpacker_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus_if ();

    byte_to_pixel_unpacker #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .MAX_ADDR(MAX_ADDR)
    ) dut (
        .dclk (clk),
        .rst  (rst),
        .bus  (bus_if)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [EXP_W-1:0]  exp_q[$];
    logic [7:0]        frame_q[$];
    int                n_tests = 0;
    int                n_fail  = 0;
    int                exp_fc  = 0;
    bit                m_found;
    bit                m_err;
    int                m_hdr_idx;
    logic [15:0]       m_sum;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] fbyte(input int i);
        return (i < 0) ? 8'h00 : frame_q[i];
    endfunction

    // Reference model: header = first place the last four bytes read 04 40 00 00
    // (bytes before the frame count as zero); payload is everything after it.
    task automatic model_frame();
        int          n;
        int          start;
        int          p;
        logic [23:0] a;
        logic [ADDR_W-1:0] ea;
        logic [NUM_CH-1:0] ew;
        logic [CNT_W-1:0]  ec;
        logic [7:0]        b;
        n         = frame_q.size();
        m_found   = 1'b0;
        m_hdr_idx = -1;
        m_sum     = '0;
        for (int k = 0; k < n; k++) begin
            if (fbyte(k-3) == 8'h04 && fbyte(k-2) == 8'h40 &&
                fbyte(k-1) == 8'h00 && fbyte(k) == 8'h00) begin
                m_found   = 1'b1;
                m_hdr_idx = k;
                break;
            end
        end
        m_err = 1'b0;
        if (m_found) begin
            a     = {fbyte(m_hdr_idx-6), fbyte(m_hdr_idx-5), fbyte(m_hdr_idx-4)};
            start = int'(a) % (1 << ADDR_W);
            if (start >= MAX_ADDR) start = 0;
            p = 0;
            for (int j = m_hdr_idx + 1; j < n; j++) begin
                b  = frame_q[j];
                ea = ADDR_W'((start + p / NUM_CH) % MAX_ADDR);
                ec = CNT_W'(p % NUM_CH);
                ew = NUM_CH'(1) << (p % NUM_CH);
                exp_q.push_back({ea, b, ew, ec, ((p % NUM_CH) == NUM_CH - 1)});
                m_sum = m_sum + 16'(b);
                p++;
            end
            m_err = ((p % NUM_CH) != 0);
        end
    endtask

    task automatic check_write();
        logic [EXP_W-1:0] e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wr_unexpected got wea=0x%0h exp no write", bus_if.wea);
        end else begin
            e = exp_q.pop_front();
            check_eq("wr_addr",     bus_if.addr2vram, e[EXP_W-1 -: ADDR_W]);
            check_eq("wr_data",     bus_if.data_rgb,  e[EXP_W-ADDR_W-1 -: DATA_W]);
            check_eq("wr_wea",      bus_if.wea,       e[NUM_CH+CNT_W -: NUM_CH]);
            check_eq("wr_count",    bus_if.count,     e[CNT_W:1]);
            check_eq("wr_pix_done", bus_if.pix_done,  e[0]);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_frame(input bit do_end);
        for (int j = 0; j < frame_q.size(); j++) begin
            bus_if.data8b = frame_q[j];
            bus_if.en     = 1'b1;
            @(posedge clk); #1;
            if (m_found && j > m_hdr_idx) begin
                check_write();
            end else begin
                check_eq("idle_wea",      bus_if.wea,      '0);
                check_eq("idle_pix_done", bus_if.pix_done, '0);
            end
            if (m_found && j == m_hdr_idx)
                check_eq("sync_state", bus_if.dbg_state, 1);
        end
        if (do_end) begin
            bus_if.en     = 1'b0;
            bus_if.data8b = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            if (m_found && exp_fc < 65535) exp_fc++;
            check_eq("end_err_short", bus_if.err_short, (m_found && m_err));
            check_eq("end_frame_cnt", bus_if.frame_cnt, exp_fc);
            check_eq("end_wea",       bus_if.wea,       '0);
            check_eq("end_state",     bus_if.dbg_state, 0);
            if (m_found) begin
                check_eq("end_addr",  bus_if.addr2vram, '0);
                check_eq("end_count", bus_if.count,     '0);
            end
`ifdef UNPACK_CHKSUM_EN
            check_eq("chksum_vld", bus_if.chksum_vld, m_found);
            if (m_found) check_eq("chksum", bus_if.chksum, m_sum);
`endif
            @(posedge clk); #1;
            check_eq("err_pulse_len", bus_if.err_short, 0);
`ifdef UNPACK_CHKSUM_EN
            check_eq("chksum_vld_len", bus_if.chksum_vld, 0);
`endif
        end
    endtask

    task automatic push_header(input logic [23:0] a);
        frame_q.push_back(a[23:16]);
        frame_q.push_back(a[15:8]);
        frame_q.push_back(a[7:0]);
        frame_q.push_back(8'h04);
        frame_q.push_back(8'h40);
        frame_q.push_back(8'h00);
        frame_q.push_back(8'h00);
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic run_frame();
        model_frame();
        drive_frame(1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_addr"},      bus_if.addr2vram, '0);
        check_eq({tag, "_data"},      bus_if.data_rgb,  '0);
        check_eq({tag, "_wea"},       bus_if.wea,       '0);
        check_eq({tag, "_count"},     bus_if.count,     '0);
        check_eq({tag, "_pix_done"},  bus_if.pix_done,  '0);
        check_eq({tag, "_err_short"}, bus_if.err_short, '0);
        check_eq({tag, "_frame_cnt"}, bus_if.frame_cnt, '0);
        check_eq({tag, "_state"},     bus_if.dbg_state, '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          sel;
        logic [23:0] ra;
        bus_if.en     = 1'b0;
        bus_if.data8b = '0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("reset");

        // two full pixels from 0x100
        frame_q.delete(); push_header(24'h000100);
        frame_q.push_back(8'hAA); frame_q.push_back(8'hBB); frame_q.push_back(8'hCC);
        frame_q.push_back(8'hDD); frame_q.push_back(8'hEE); frame_q.push_back(8'hFF);
        run_frame();

        // short frame: two bytes of one pixel
        frame_q.delete(); push_header(24'h000200);
        frame_q.push_back(8'hAA); frame_q.push_back(8'hBB);
        run_frame();

        // address wrap at MAX_ADDR-1
        frame_q.delete(); push_header(24'h012BFF);
        push_rand(6);
        run_frame();

        // marker look-alike inside payload stays data
        frame_q.delete(); push_header(24'h000010);
        push_rand(2);
        frame_q.push_back(8'h04); frame_q.push_back(8'h40);
        frame_q.push_back(8'h00); frame_q.push_back(8'h00);
        push_rand(3);
        run_frame();

        // out-of-range and upper-bit addresses, header-only frame, no-header frame
        frame_q.delete(); push_header(24'h012C00); push_rand(3); run_frame();
        frame_q.delete(); push_header(24'hFE0005); push_rand(4); run_frame();
        frame_q.delete(); push_header(24'h000321); run_frame();
        frame_q.delete(); push_rand(1); frame_q.push_back(8'h11); push_rand(5); run_frame();

        // reset in the middle of a pixel
        frame_q.delete(); push_header(24'h000040);
        frame_q.push_back(8'h11); frame_q.push_back(8'h22);
        frame_q.push_back(8'h33); frame_q.push_back(8'h44);
        model_frame();
        drive_frame(1'b0);
        rst           = 1'b1;
        bus_if.en     = 1'b1;
        bus_if.data8b = 8'h55;
        @(posedge clk); #1;
        rst    = 1'b0;
        exp_fc = 0;
        check_all_zero("mid_rst");
        frame_q.delete();
        frame_q.push_back(8'h66); frame_q.push_back(8'h77); frame_q.push_back(8'h88);
        run_frame();

        // randomized frames
        for (int f = 0; f < 24; f++) begin
            frame_q.delete();
            push_rand($urandom_range(0, 4));
            sel = $urandom_range(0, 3);
            case (sel)
                0: ra = 24'($urandom_range(0, 200));
                1: ra = 24'($urandom_range(MAX_ADDR - 5, MAX_ADDR - 1));
                2: ra = 24'($urandom_range(MAX_ADDR, 131071));
                default: ra = 24'($urandom);
            endcase
            push_header(ra);
            push_rand($urandom_range(0, 12));
            run_frame();
        end

        check_eq("exp_q_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
